mips_timer: RTL and testbench

- Memory-mapped timer/compare peripheral on the single-cycle MIPS data bus, directly downstream of the CPU's memory-access stage.
- Consumes the CPU's memwrite, memaddr and memwritedata outputs.
- Returns combinational read data and a hit strobe to the system read-data mux in the same cycle.
- Raises a level interrupt on a compare match.

---
 rtl/mips_timer_pkg.sv | 20 ++
 rtl/timer_prescaler.sv | 37 +++
 rtl/mips_timer.sv | 109 ++++++++++
 tb/tb_mips_timer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_timer_pkg.sv
// mips_timer_pkg
// Shared constants for the memory-mapped timer/compare peripheral:
// register word offsets within the 32-byte window, CTRL bit positions,
// and the reset value of the COMPARE register.
package mips_timer_pkg;

  localparam logic [4:0] TMR_CTRL     = 5'h00;
  localparam logic [4:0] TMR_PRESCALE = 5'h04;
  localparam logic [4:0] TMR_COUNT    = 5'h08;
  localparam logic [4:0] TMR_COMPARE  = 5'h0C;
  localparam logic [4:0] TMR_STATUS   = 5'h10;

  localparam int CTRL_EN         = 0;
  localparam int CTRL_AUTORELOAD = 1;
  localparam int CTRL_IRQEN      = 2;
  localparam int CTRL_ONESHOT    = 3;

  localparam logic [31:0] COMPARE_RST = 32'hFFFF_FFFF;

endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler
// Divides the clock by (prescale + 1) while enabled.
//   clk      - system clock, rising edge
//   reset    - asynchronous, active-low reset
//   en       - count enable; pre_cnt holds while low
//   prescale - terminal value; tick fires when pre_cnt reaches it
//   restart  - synchronous restart of pre_cnt; suppresses tick this cycle
//   tick     - one-cycle strobe, combinational on registered state
module timer_prescaler
  import mips_timer_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] prescale,
  input  logic         restart,
  output logic         tick
);

  logic [W-1:0] pre_cnt;

  assign tick = en & ~restart & (pre_cnt == prescale);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_cnt <= '0;
    end else if (restart) begin
      pre_cnt <= '0;
    end else if (en) begin
      if (tick) pre_cnt <= '0;
      else      pre_cnt <= pre_cnt + W'(1);
    end
  end

endmodule

// File: rtl/mips_timer.sv
// mips_timer
// Timer/compare peripheral on the single-cycle MIPS data bus.
//   clk          - system clock, rising edge
//   reset        - asynchronous, active-low reset
//   memwrite     - CPU store strobe (MEM stage)
//   memaddr      - CPU byte address (MEM stage)
//   memwritedata - CPU store data
//   readdata     - combinational register read data, 0 when not hit
//   hit          - address falls in the 32-byte register window
//   irq          - level interrupt: match_flag & CTRL.irqen
module mips_timer
  import mips_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0100,
  parameter int          PRESCALE_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] memaddr,
  input  logic [31:0] memwritedata,
  output logic [31:0] readdata,
  output logic        hit,
  output logic        irq
);

  logic [3:0]            ctrl;
  logic [PRESCALE_W-1:0] prescale;
  logic [31:0]           count;
  logic [31:0]           compare;
  logic                  match_flag;

  logic [4:0] offset;
  logic       wr;
  logic       wr_ctrl, wr_prescale, wr_count, wr_compare, wr_status;
  logic       tick, match;

  // Byte lane bits are don't-care; accesses are always whole words.
  logic unused_ok;
  assign unused_ok = ^memaddr[1:0];

  assign hit    = (memaddr[31:5] == BASE_ADDR[31:5]);
  assign offset = {memaddr[4:2], 2'b00};
  assign wr     = memwrite & hit;

  assign wr_ctrl     = wr & (offset == TMR_CTRL);
  assign wr_prescale = wr & (offset == TMR_PRESCALE);
  assign wr_count    = wr & (offset == TMR_COUNT);
  assign wr_compare  = wr & (offset == TMR_COMPARE);
  assign wr_status   = wr & (offset == TMR_STATUS);

  // A COUNT load also restarts the prescaler so the new value gets a
  // full prescale period, and the suppressed tick means no match is
  // evaluated against the value being overwritten.
  timer_prescaler #(.W(PRESCALE_W)) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .en       (ctrl[CTRL_EN]),
    .prescale (prescale),
    .restart  (wr_prescale | wr_count),
    .tick     (tick)
  );

  assign match = tick & (count == compare);
  assign irq   = match_flag & ctrl[CTRL_IRQEN];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl       <= '0;
      prescale   <= '0;
      count      <= '0;
      compare    <= COMPARE_RST;
      match_flag <= 1'b0;
    end else begin
      // Software write to CTRL takes priority over the oneshot auto-clear.
      if (wr_ctrl)                          ctrl          <= memwritedata[3:0];
      else if (match && ctrl[CTRL_ONESHOT]) ctrl[CTRL_EN] <= 1'b0;

      if (wr_prescale) prescale <= memwritedata[PRESCALE_W-1:0];
      if (wr_compare)  compare  <= memwritedata;

      if (wr_count) begin
        count <= memwritedata;
      end else if (tick) begin
        if (match && ctrl[CTRL_AUTORELOAD]) count <= '0;
        else                                count <= count + 32'd1;
      end

      // A new match beats a coincident write-1-to-clear.
      if (match)                              match_flag <= 1'b1;
      else if (wr_status && memwritedata[0])  match_flag <= 1'b0;
    end
  end

  always_comb begin
    readdata = '0;
    if (hit) begin
      unique case (offset)
        TMR_CTRL:     readdata = {28'h0, ctrl};
        TMR_PRESCALE: readdata = 32'(prescale);
        TMR_COUNT:    readdata = count;
        TMR_COMPARE:  readdata = compare;
        TMR_STATUS:   readdata = {31'h0, match_flag};
        default:      readdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_timer.sv
`timescale 1ns/1ps
module tb_mips_timer;

  localparam logic [31:0] B      = 32'hFFFF_0100;
  localparam logic [31:0] A_CTRL = B + 32'h00;
  localparam logic [31:0] A_PRE  = B + 32'h04;
  localparam logic [31:0] A_CNT  = B + 32'h08;
  localparam logic [31:0] A_CMP  = B + 32'h0C;
  localparam logic [31:0] A_ST   = B + 32'h10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        memwrite = 1'b0;
  logic [31:0] memaddr = '0;
  logic [31:0] memwritedata = '0;
  logic [31:0] readdata;
  logic        hit;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;

  mips_timer dut (
    .clk          (clk),
    .reset        (reset),
    .memwrite     (memwrite),
    .memaddr      (memaddr),
    .memwritedata (memwritedata),
    .readdata     (readdata),
    .hit          (hit),
    .irq          (irq)
  );

  always #10 clk = ~clk;

  // One record per clock cycle: bus inputs for the cycle, and the
  // outputs expected before the edge (state left by the previous edge).
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        chk_rd;
    logic [31:0] rd;
    logic        hit;
    logic        irq;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                     input logic chk_rd, input logic [31:0] rd, input logic h, input logic i);
    vec_t v;
    v.we = we; v.addr = addr; v.wd = wd;
    v.chk_rd = chk_rd; v.rd = rd; v.hit = h; v.irq = i;
    vt.push_back(v);
  endtask

  task automatic rdv(input logic [31:0] addr, input logic [31:0] exp, input logic i);
    add(1'b0, addr, 32'h0, 1'b1, exp, 1'b1, i);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic i);
    add(1'b1, addr, data, 1'b0, 32'h0, 1'b1, i);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_cycle(input vec_t v, input int idx);
    @(negedge clk);
    memwrite     = v.we;
    memaddr      = v.addr;
    memwritedata = v.wd;
    #2;
    if (v.chk_rd) check($sformatf("vec%0d readdata", idx), readdata, v.rd);
    check($sformatf("vec%0d hit", idx), {31'h0, hit}, {31'h0, v.hit});
    check($sformatf("vec%0d irq", idx), {31'h0, irq}, {31'h0, v.irq});
    @(posedge clk);
    #1;
    memwrite = 1'b0;
  endtask

  task automatic run_from(input int start);
    for (int k = start; k < vt.size(); k++) do_cycle(vt[k], k);
  endtask

  int mark;

  initial begin
    // ---- reset state and decode
    rdv(A_CTRL, 32'h0, 0);
    rdv(A_PRE,  32'h0, 0);
    rdv(A_CNT,  32'h0, 0);
    rdv(A_CMP,  32'hFFFF_FFFF, 0);
    rdv(A_ST,   32'h0, 0);
    rdv(B + 32'h14, 32'h0, 0);
    rdv(B + 32'h1C, 32'h0, 0);
    add(1'b0, B + 32'h20, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0);
    add(1'b0, 32'h0000_0108, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0);
    add(1'b1, B + 32'h20, 32'h1, 1'b0, 32'h0, 1'b0, 1'b0);
    rdv(A_CTRL, 32'h0, 0);

    // ---- autoreload with irq, compare = 3, prescale = 0
    wr(A_PRE, 32'h0, 0);
    wr(A_CMP, 32'h3, 0);
    rdv(B + 32'h0F, 32'h3, 0);
    wr(A_CTRL, 32'h7, 0);
    rdv(A_CNT, 32'h0, 0);
    rdv(A_CNT, 32'h1, 0);
    rdv(A_CNT, 32'h2, 0);
    rdv(A_CNT, 32'h3, 0);            // match edge: flag sets, COUNT -> 0
    wr(A_ST, 32'h1, 1);              // clear
    rdv(A_ST, 32'h0, 0);
    rdv(A_CNT, 32'h2, 0);
    rdv(A_CNT, 32'h3, 0);            // match again
    rdv(A_ST, 32'h1, 1);
    wr(A_ST, 32'h0, 1);              // write-0: no effect
    rdv(A_ST, 32'h1, 1);
    wr(A_CTRL, 32'h3, 1);            // drop irqen on a match edge
    rdv(A_ST, 32'h1, 0);
    rdv(A_CNT, 32'h1, 0);
    rdv(A_CNT, 32'h2, 0);
    wr(A_ST, 32'h1, 0);              // clear coincident with match: set wins
    rdv(A_ST, 32'h1, 0);
    wr(A_CTRL, 32'h0, 0);            // last tick 1 -> 2, then stop
    rdv(A_CNT, 32'h2, 0);
    rdv(A_CNT, 32'h2, 0);
    wr(A_ST, 32'h1, 0);
    rdv(A_ST, 32'h0, 0);
    rdv(A_CTRL, 32'h0, 0);

    // ---- prescaler = 2, restart on PRESCALE write, COUNT write on tick
    wr(A_CNT, 32'h0, 0);
    wr(A_PRE, 32'h2, 0);
    wr(A_CTRL, 32'h1, 0);
    rdv(A_CNT, 32'h0, 0);
    rdv(A_CNT, 32'h0, 0);
    rdv(A_CNT, 32'h0, 0);
    rdv(A_CNT, 32'h1, 0);
    rdv(A_CNT, 32'h1, 0);
    rdv(A_CNT, 32'h1, 0);
    rdv(A_CNT, 32'h2, 0);            // pre_cnt now 1
    wr(A_PRE, 32'h2, 0);             // restart
    rdv(A_CNT, 32'h2, 0);
    rdv(A_CNT, 32'h2, 0);
    rdv(A_CNT, 32'h2, 0);            // tick 3 cycles after the write
    rdv(A_CNT, 32'h3, 0);
    rdv(A_CNT, 32'h3, 0);
    wr(A_CNT, 32'd100, 0);           // would have been a tick edge
    rdv(A_CNT, 32'd100, 0);
    rdv(A_CNT, 32'd100, 0);
    rdv(A_CNT, 32'd100, 0);
    rdv(A_CNT, 32'd101, 0);
    wr(A_CTRL, 32'h0, 0);
    rdv(A_PRE, 32'h2, 0);

    // ---- oneshot with 32-bit wrap
    wr(A_PRE, 32'h0, 0);
    wr(A_CMP, 32'hFFFF_FFFF, 0);
    wr(A_CNT, 32'hFFFF_FFFE, 0);
    wr(A_CTRL, 32'h9, 0);
    rdv(A_CNT, 32'hFFFF_FFFE, 0);
    rdv(A_CNT, 32'hFFFF_FFFF, 0);    // match: wrap to 0, en clears
    rdv(A_ST, 32'h1, 0);
    rdv(A_CTRL, 32'h8, 0);
    rdv(A_CNT, 32'h0, 0);
    rdv(A_CNT, 32'h0, 0);
    wr(A_ST, 32'h1, 0);
    rdv(A_ST, 32'h0, 0);

    // ---- CTRL write on a oneshot match edge keeps en
    wr(A_CMP, 32'h2, 0);
    wr(A_CNT, 32'h0, 0);
    wr(A_CTRL, 32'hD, 0);
    rdv(A_CNT, 32'h0, 0);
    rdv(A_CNT, 32'h1, 0);
    wr(A_CTRL, 32'h1, 0);            // match edge
    rdv(A_CTRL, 32'h1, 0);
    rdv(A_ST, 32'h1, 0);
    rdv(A_CNT, 32'h5, 0);
    wr(A_CTRL, 32'h5, 0);
    rdv(A_ST, 32'h1, 1);
    rdv(A_CNT, 32'h8, 1);

    #25;
    reset = 1'b1;
    run_from(0);

    // ---- asynchronous reset for part of a cycle while counting with irq up
    @(negedge clk);
    memwrite = 1'b0;
    memaddr  = A_CNT;
    #1 reset = 1'b0;
    #1 check("rst count", readdata, 32'h0);
    check("rst irq", {31'h0, irq}, 32'h0);
    memaddr = A_CTRL; #1 check("rst ctrl", readdata, 32'h0);
    memaddr = A_CMP;  #1 check("rst compare", readdata, 32'hFFFF_FFFF);
    memaddr = A_ST;   #1 check("rst status", readdata, 32'h0);
    memaddr = A_PRE;  #1 check("rst prescale", readdata, 32'h0);
    #1 reset = 1'b1;

    mark = vt.size();
    rdv(A_CNT, 32'h0, 0);
    rdv(A_CNT, 32'h0, 0);
    rdv(A_CTRL, 32'h0, 0);
    wr(A_CTRL, 32'h1, 0);
    rdv(A_CNT, 32'h0, 0);
    rdv(A_CNT, 32'h1, 0);
    rdv(A_CNT, 32'h2, 0);
    run_from(mark);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
